mem_check_sequencer: RTL and testbench
======================================

Name: mem_check_sequencer

Overview:
- Hardware self-check stage on the shared 256-bit DataBus, directly downstream of the stop-instruction check performed at the top level.
- Snoops the bus for the STOP opcode, then requests bus ownership and reads NUM_LOCS main-memory locations in order.
- Compares each location against a preloaded expected-value/mask table and reports per-location fail flags and an overall pass flag.
- Replaces the simulation-only memory dump with synthesizable checking.

Parameters:
- NUM_LOCS, 12, number of consecutive memory locations checked.
- BASE_ADDR, 16'h0000, address of the first checked location.
- STOP_OPCODE, 32'hff000000, value on DataBus[31:0] that triggers the check.
- MEM_LATENCY, 1, cycles from nRead low until main memory drives valid data.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- DataBus  in  256  snooped shared data bus.
- BusReq  out  1  request for ownership of Address/nRead.
- BusGrant  in  1  ownership granted by Execution.
- BusOwn  out  1  high while this block drives Address/nRead; top muxes on it.
- Address  out  16  read address, valid only when BusOwn=1.
- nRead  out  1  active-low read strobe.
- ExpWrEn  in  1  expected-table write enable.
- ExpIdx  in  $clog2(NUM_LOCS)  table entry index.
- ExpData  in  256  expected value.
- ExpMask  in  256  compare mask; 1 = bit compared.
- Clear  in  1  return from DONE to IDLE.
- Done  out  1  check complete.
- Pass  out  1  Done and no failures.
- FailMask  out  NUM_LOCS  bit i set when location i mismatched.
- FirstFailIdx  out  $clog2(NUM_LOCS+1)  lowest failing index; NUM_LOCS if none.

Behaviour:
- Reset values (asynchronous): state IDLE, BusReq=0, BusOwn=0, Address=0, nRead=1, Done=0, Pass=0, FailMask=0, FirstFailIdx=NUM_LOCS, index=0, all table data=0, all table masks=all-ones.
- Table writes are accepted only in IDLE or DONE. A write with ExpIdx>=NUM_LOCS is ignored. Writes in other states are ignored.
- IDLE: on a rising edge where DataBus[31:0]==STOP_OPCODE, move to REQ. BusReq=1 from the next cycle.
- REQ: hold BusReq=1. When BusGrant=1 is sampled, move to READ with BusOwn=1, Address=BASE_ADDR+index and nRead=0 in the same next cycle.
- READ: nRead=0 for exactly MEM_LATENCY+1 cycles, counted by an internal counter. DataBus is sampled on the edge ending the last READ cycle.
  - FailMask[index] <= |((DataBus ^ ExpData[index]) & ExpMask[index]).
  - Move to GAP.
- GAP: one cycle with nRead=1 and Address held.
  - If index==NUM_LOCS-1, go to DONE.
  - Otherwise increment index and go to READ.
- Per-location cost is MEM_LATENCY+2 cycles. Address is 16-bit and wraps modulo 2^16.
- DONE:
  - BusReq=0, BusOwn=0, nRead=1, Address=0.
  - Done=1. Pass=(FailMask==0). FirstFailIdx is registered on entry.
  - Outputs hold until Clear or Reset.
  - Clear=1 in DONE goes to IDLE and zeroes Done, Pass, FailMask and index. FirstFailIdx returns to NUM_LOCS.
  - Clear is ignored in all other states.
- BusGrant dropping in READ or GAP:
  - Next cycle: nRead=1, BusOwn=0, state REQ.
  - No compare is recorded for the interrupted location. The same index is retried after re-grant.
- STOP_OPCODE seen outside IDLE is ignored, including in DONE.
- Reset asserted mid-operation returns to reset values immediately, releasing the bus. The table is also reinitialised.

Test Plan:
- Preload idx0 = 256'h0009000c…000e0006 with full mask. Memory holds the same value; NUM_LOCS=1. Drive 32'hff000000, grant after 3 cycles -> Address=0, nRead low 2 cycles, Done=1, Pass=1, FirstFailIdx=1.
- 12 locations, location 5 differs in bit 0, location 10 differs only in bits [255:16] with mask 256'hffff -> FailMask=12'h020, Pass=0, FirstFailIdx=5.
- MEM_LATENCY=3, grant held -> per-location nRead low 4 cycles then high 1 cycle; total from grant to Done = 12*5 cycles.
- Drop BusGrant during READ of index 4 for 2 cycles -> nRead=1 next cycle, BusReq held; after re-grant Address=BASE_ADDR+4 re-issued; final FailMask correct.
- Assert Reset during index 7 -> same-cycle BusOwn=0, nRead=1, Done=0. Subsequent stop opcode restarts at index 0 with reset table (zeros, full mask).
- In DONE: ExpWrEn to idx 2 accepted and a second stop opcode ignored. Clear -> Done=0, FailMask=0. A new stop opcode runs a fresh check using the updated table.

Source files
------------

// File: rtl/mem_check_sequencer.sv
// mem_check_sequencer: after a STOP opcode on the bus, reads NUM_LOCS memory locations
// and checks each against a masked expected-value table, reporting per-location failures.
module mem_check_sequencer #(
    parameter int          NUM_LOCS    = 12,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter logic [31:0] STOP_OPCODE = 32'hff000000,
    parameter int          MEM_LATENCY = 1,
    localparam int IW = (NUM_LOCS > 1) ? $clog2(NUM_LOCS) : 1,
    localparam int FW = $clog2(NUM_LOCS + 1)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [255:0]        DataBus,
    output logic                BusReq,
    input  logic                BusGrant,
    output logic                BusOwn,
    output logic [15:0]         Address,
    output logic                nRead,
    input  logic                ExpWrEn,
    input  logic [IW-1:0]       ExpIdx,
    input  logic [255:0]        ExpData,
    input  logic [255:0]        ExpMask,
    input  logic                Clear,
    output logic                Done,
    output logic                Pass,
    output logic [NUM_LOCS-1:0] FailMask,
    output logic [FW-1:0]       FirstFailIdx
);
    localparam int CW = $clog2(MEM_LATENCY + 2);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_READ = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                bus_req_q, bus_req_d, bus_own_q, bus_own_d, n_read_q, n_read_d;
    logic [15:0]         addr_q, addr_d;
    logic                done_q, done_d, pass_q, pass_d;
    logic [NUM_LOCS-1:0] fail_q, fail_d;
    logic [FW-1:0]       ffi_q, ffi_d, first_fail;
    logic [255:0]        exp_data_q [NUM_LOCS];
    logic [255:0]        exp_data_d [NUM_LOCS];
    logic [255:0]        exp_mask_q [NUM_LOCS];
    logic [255:0]        exp_mask_d [NUM_LOCS];
    logic                wr_ok, miss;

    assign wr_ok = ExpWrEn && (state_q == S_IDLE || state_q == S_DONE) && (32'(ExpIdx) < NUM_LOCS);
    assign miss  = |((DataBus ^ exp_data_q[idx_q]) & exp_mask_q[idx_q]);

    always_comb begin
        exp_data_d = exp_data_q;
        exp_mask_d = exp_mask_q;
        if (wr_ok) begin
            exp_data_d[ExpIdx] = ExpData;
            exp_mask_d[ExpIdx] = ExpMask;
        end
    end

    // Scan from the top so the lowest failing index wins.
    always_comb begin
        first_fail = FW'(NUM_LOCS);
        for (int i = NUM_LOCS - 1; i >= 0; i--)
            if (fail_q[i]) first_fail = FW'(i);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        bus_req_d = bus_req_q;
        bus_own_d = bus_own_q;
        addr_d    = addr_q;
        n_read_d  = n_read_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        ffi_d     = ffi_q;
        case (state_q)
            S_IDLE: if (DataBus[31:0] == STOP_OPCODE) begin
                state_d   = S_REQ;
                bus_req_d = 1'b1;
            end
            S_REQ: if (BusGrant) begin
                state_d   = S_READ;
                bus_own_d = 1'b1;
                addr_d    = BASE_ADDR + 16'(idx_q);
                n_read_d  = 1'b0;
                cnt_d     = '0;
            end
            S_READ, S_GAP: begin
                if (!BusGrant) begin
                    // Losing the bus abandons the current location; it is retried on re-grant.
                    state_d   = S_REQ;
                    bus_own_d = 1'b0;
                    n_read_d  = 1'b1;
                end else if (state_q == S_READ) begin
                    if (cnt_q == CW'(MEM_LATENCY)) begin
                        state_d       = S_GAP;
                        n_read_d      = 1'b1;
                        fail_d[idx_q] = miss;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (32'(idx_q) == NUM_LOCS - 1) begin
                    state_d   = S_DONE;
                    bus_req_d = 1'b0;
                    bus_own_d = 1'b0;
                    addr_d    = '0;
                    done_d    = 1'b1;
                    pass_d    = ~|fail_q;
                    ffi_d     = first_fail;
                end else begin
                    state_d  = S_READ;
                    idx_d    = idx_q + IW'(1);
                    addr_d   = BASE_ADDR + 16'(idx_q) + 16'd1;
                    n_read_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            S_DONE: if (Clear) begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                fail_d  = '0;
                idx_d   = '0;
                ffi_d   = FW'(NUM_LOCS);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            bus_req_q  <= 1'b0;
            bus_own_q  <= 1'b0;
            addr_q     <= '0;
            n_read_q   <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= '0;
            ffi_q      <= FW'(NUM_LOCS);
            exp_data_q <= '{default: '0};
            exp_mask_q <= '{default: '1};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            bus_req_q  <= bus_req_d;
            bus_own_q  <= bus_own_d;
            addr_q     <= addr_d;
            n_read_q   <= n_read_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ffi_q      <= ffi_d;
            exp_data_q <= exp_data_d;
            exp_mask_q <= exp_mask_d;
        end
    end

    assign BusReq       = bus_req_q;
    assign BusOwn       = bus_own_q;
    assign Address      = addr_q;
    assign nRead        = n_read_q;
    assign Done         = done_q;
    assign Pass         = pass_q;
    assign FailMask     = fail_q;
    assign FirstFailIdx = ffi_q;
endmodule

// File: tb/tb_mem_check_sequencer.sv
// tb_mem_check_sequencer: directed checks of mem_check_sequencer with a behavioural main memory.
module tb_mem_check_sequencer;
    logic         clk = 1'b0, rst = 1'b1;
    logic         stop = 1'b0, grant = 1'b0, exp_wr = 1'b0, clear = 1'b0;
    logic [3:0]   exp_idx = '0;
    logic [255:0] exp_data = '0, exp_mask = '0, data_bus;
    logic         bus_req, bus_own, n_read, done, pass;
    logic [15:0]  addr;
    logic [11:0]  fail_mask;
    logic [3:0]   ffi;
    logic [255:0] mem [16];
    int           n_chk = 0, n_bad = 0, n = 0;

    mem_check_sequencer dut (
        .Clk(clk), .Reset(rst), .DataBus(data_bus),
        .BusReq(bus_req), .BusGrant(grant), .BusOwn(bus_own),
        .Address(addr), .nRead(n_read),
        .ExpWrEn(exp_wr), .ExpIdx(exp_idx), .ExpData(exp_data), .ExpMask(exp_mask),
        .Clear(clear), .Done(done), .Pass(pass),
        .FailMask(fail_mask), .FirstFailIdx(ffi)
    );

    always #5 clk = ~clk;

    assign data_bus = stop ? {224'd0, 32'hff000000} :
                      (bus_own && !n_read) ? mem[addr[3:0]] : '0;

    function automatic logic [255:0] pat(input int i);
        return {8{32'(i) * 32'h01010101 + 32'h00100007}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input logic [255:0] d, input logic [255:0] m);
        exp_wr = 1'b1; exp_idx = 4'(i); exp_data = d; exp_mask = m;
        tick;
        exp_wr = 1'b0;
    endtask

    task automatic start_run(input int wait_n);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        repeat (wait_n) tick;
        grant = 1'b1;
        tick;
    endtask

    task automatic wait_done;
        while (!done && n < 300) begin
            tick;
            n++;
        end
        chk("done_seen", done, 1);
        grant = 1'b0;
    endtask

    task automatic wait_addr(input int k);
        int t = 0;
        while (!(addr == 16'(k) && bus_own && !n_read) && t < 300) begin
            tick;
            t++;
        end
        chk("reach_addr", addr, k);
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = pat(i);
        mem[5]  = pat(5) ^ 256'h1;
        mem[10] = pat(10) ^ {55'd1, 200'd0} ^ {239'd1, 16'd0};
        repeat (2) tick;
        rst = 1'b0;
        tick;
        chk("rst_busreq", bus_req, 0);
        chk("rst_busown", bus_own, 0);
        chk("rst_addr", addr, 0);
        chk("rst_nread", n_read, 1);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_failmask", fail_mask, 0);
        chk("rst_ffi", ffi, 12);

        for (int i = 0; i < 12; i++) wr(i, pat(i), (i == 10) ? 256'hffff : '1);

        // Run 1: grant after 3 cycles, check per-location timing and totals.
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("req_rise", bus_req, 1);
        chk("req_no_own", bus_own, 0);
        repeat (3) tick;
        chk("req_hold", bus_req, 1);
        chk("req_wait_own", bus_own, 0);
        grant = 1'b1;
        tick;
        n = 0;
        chk("grant_own", bus_own, 1);
        chk("grant_addr", addr, 0);
        chk("grant_nread", n_read, 0);
        tick; n++;
        chk("read2_nread", n_read, 0);
        tick; n++;
        chk("gap_nread", n_read, 1);
        chk("gap_addr", addr, 0);
        tick; n++;
        chk("loc1_addr", addr, 1);
        chk("loc1_nread", n_read, 0);
        wait_done;
        chk("run1_cycles", n, 36);
        chk("run1_pass", pass, 0);
        chk("run1_failmask", fail_mask, 12'h020);
        chk("run1_ffi", ffi, 5);
        chk("done_busreq", bus_req, 0);
        chk("done_busown", bus_own, 0);
        chk("done_nread", n_read, 1);
        chk("done_addr", addr, 0);

        // Table writes in DONE are accepted; a stop opcode there is ignored.
        wr(5, mem[5], '1);
        wr(2, ~pat(2), '1);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("done_stop_busreq", bus_req, 0);
        chk("done_stop_done", done, 1);
        do_clear;
        chk("clr_done", done, 0);
        chk("clr_pass", pass, 0);
        chk("clr_failmask", fail_mask, 0);
        chk("clr_ffi", ffi, 12);

        // Run 2: updated table; a write while busy must be ignored.
        start_run(1);
        n = 0;
        exp_wr = 1'b1; exp_idx = 4'd0; exp_data = '1; exp_mask = '1;
        tick;
        exp_wr = 1'b0;
        wait_done;
        chk("run2_pass", pass, 0);
        chk("run2_failmask", fail_mask, 12'h004);
        chk("run2_ffi", ffi, 2);
        do_clear;

        // Run 3: grant drops for 2 cycles at the start of location 4.
        start_run(0);
        wait_addr(4);
        grant = 1'b0;
        tick;
        chk("drop_nread", n_read, 1);
        chk("drop_busown", bus_own, 0);
        chk("drop_busreq", bus_req, 1);
        tick;
        chk("drop2_busreq", bus_req, 1);
        chk("drop2_busown", bus_own, 0);
        grant = 1'b1;
        tick;
        chk("regrant_own", bus_own, 1);
        chk("regrant_addr", addr, 4);
        chk("regrant_nread", n_read, 0);
        n = 0;
        wait_done;
        chk("run3_failmask", fail_mask, 12'h004);
        chk("run3_ffi", ffi, 2);
        do_clear;

        // Run 4: asynchronous reset in the middle of location 7.
        start_run(0);
        wait_addr(7);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busown", bus_own, 0);
        chk("arst_nread", n_read, 1);
        chk("arst_done", done, 0);
        chk("arst_busreq", bus_req, 0);
        grant = 1'b0;
        tick;
        rst = 1'b0;
        tick;

        // Run 5: table is back to zeros with full mask, so every nonzero location fails.
        start_run(2);
        chk("run5_addr0", addr, 0);
        n = 0;
        wait_done;
        chk("run5_pass", pass, 0);
        chk("run5_failmask", fail_mask, 12'hfff);
        chk("run5_ffi", ffi, 0);
        do_clear;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
